// File: rtl/poly_sub_ctrl_if.sv
// rtl/poly_sub_ctrl_if.sv - scheduler, coefficient RAM and mod_sub signal bundle for poly_sub_ctrl
interface poly_sub_ctrl_if #(
    parameter int AW = 8
);
    logic          start_i;
    logic [22:0]   q_i;
    logic          hold_i;
    logic          busy_o;
    logic          done_o;
    logic          rd_en_o;
    logic [AW-1:0] rd_addr_o;
    logic [23:0]   a_rdata_i;
    logic [23:0]   b_rdata_i;
    logic [23:0]   sub_a_o;
    logic [23:0]   sub_b_o;
    logic [22:0]   sub_q_o;
    logic [22:0]   sub_c_i;
    logic          wr_en_o;
    logic [AW-1:0] wr_addr_o;
    logic [22:0]   wr_data_o;

    modport master (
        input  start_i, q_i, hold_i, a_rdata_i, b_rdata_i, sub_c_i,
        output busy_o, done_o, rd_en_o, rd_addr_o, sub_a_o, sub_b_o, sub_q_o,
               wr_en_o, wr_addr_o, wr_data_o
    );

    modport slave (
        output start_i, q_i, hold_i, a_rdata_i, b_rdata_i, sub_c_i,
        input  busy_o, done_o, rd_en_o, rd_addr_o, sub_a_o, sub_b_o, sub_q_o,
               wr_en_o, wr_addr_o, wr_data_o
    );
endinterface

// File: rtl/poly_sub_ctrl.sv
// rtl/poly_sub_ctrl.sv - sequencer for element-wise modular subtraction of two coefficient RAMs
module poly_sub_ctrl #(
    parameter int N  = 256,
    parameter int AW = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    poly_sub_ctrl_if.master   bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [AW-1:0] LAST = AW'(N - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          issue;
    logic          done;
    logic          advance;

    logic          rd_pend_q;
    logic [AW-1:0] rd_addr_pend_q;
    logic          sub_vld_q;
    logic [AW-1:0] sub_addr_q;
    logic [23:0]   sub_a_q, sub_b_q;
    logic [22:0]   sub_q_q;
    logic          wr_vld_q;
    logic [AW-1:0] wr_addr_q;
    logic [22:0]   wr_data_q;

    // hold freezes every register; nothing below updates unless advance is set
    assign advance = !bus.hold_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        issue   = 1'b0;
        done    = 1'b0;
        if (advance) begin
            case (state_q)
                IDLE: begin
                    if (bus.start_i) begin
                        cnt_d   = '0;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    issue = 1'b1;
                    // the counter parks on the last address instead of wrapping
                    if (cnt_q == LAST) state_d = DRAIN;
                    else               cnt_d   = cnt_q + 1'b1;
                end
                DRAIN: begin
                    if (!rd_pend_q && !sub_vld_q) state_d = DONE;
                end
                DONE: begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            rd_pend_q      <= 1'b0;
            rd_addr_pend_q <= '0;
            sub_vld_q      <= 1'b0;
            sub_addr_q     <= '0;
            sub_a_q        <= '0;
            sub_b_q        <= '0;
            sub_q_q        <= '0;
            wr_vld_q       <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
        end else if (advance) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_pend_q <= issue;
            sub_vld_q <= rd_pend_q;
            wr_vld_q  <= sub_vld_q;
            if (state_q == IDLE && bus.start_i) sub_q_q <= bus.q_i;
            if (issue) rd_addr_pend_q <= cnt_q;
            if (rd_pend_q) begin
                sub_a_q    <= bus.a_rdata_i;
                sub_b_q    <= bus.b_rdata_i;
                sub_addr_q <= rd_addr_pend_q;
            end
            if (sub_vld_q) begin
                wr_addr_q <= sub_addr_q;
                wr_data_q <= bus.sub_c_i;
            end
        end
    end

    assign bus.busy_o    = (state_q != IDLE);
    assign bus.done_o    = done;
    assign bus.rd_en_o   = issue;
    assign bus.rd_addr_o = cnt_q;
    assign bus.sub_a_o   = sub_a_q;
    assign bus.sub_b_o   = sub_b_q;
    assign bus.sub_q_o   = sub_q_q;
    assign bus.wr_en_o   = wr_vld_q && advance;
    assign bus.wr_addr_o = wr_addr_q;
    assign bus.wr_data_o = wr_data_q;
endmodule

// File: tb/tb_poly_sub_ctrl.sv
// tb/tb_poly_sub_ctrl.sv - scoreboard bench for poly_sub_ctrl at N=4, N=256 and N=1
module tb_poly_sub_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start = 1'b0;
    logic        hold  = 1'b0;
    logic [22:0] q     = '0;
    int          sel   = 0;

    logic [23:0] mem_a [256];
    logic [23:0] mem_b [256];

    function automatic logic [22:0] mod_sub(logic [23:0] a, logic [23:0] b, logic [22:0] m);
        logic [25:0] t;
        if (a < b) t = {2'b0, a} - {2'b0, b} + {3'b0, m};
        else       t = {2'b0, a} - {2'b0, b};
        return t[22:0];
    endfunction

    poly_sub_ctrl_if #(.AW(8)) bus4 ();
    poly_sub_ctrl_if #(.AW(8)) bus256 ();
    poly_sub_ctrl_if #(.AW(1)) bus1 ();

    poly_sub_ctrl #(.N(4),   .AW(8)) dut4   (.clk_i(clk), .rst_n_i(rst_n), .bus(bus4));
    poly_sub_ctrl #(.N(256), .AW(8)) dut256 (.clk_i(clk), .rst_n_i(rst_n), .bus(bus256));
    poly_sub_ctrl #(.N(1),   .AW(1)) dut1   (.clk_i(clk), .rst_n_i(rst_n), .bus(bus1));

    assign bus4.start_i   = start && (sel == 0);
    assign bus256.start_i = start && (sel == 1);
    assign bus1.start_i   = start && (sel == 2);
    assign bus4.hold_i    = hold && (sel == 0);
    assign bus256.hold_i  = hold && (sel == 1);
    assign bus1.hold_i    = hold && (sel == 2);
    assign bus4.q_i       = q;
    assign bus256.q_i     = q;
    assign bus1.q_i       = q;

    // RAM models keep their read data while rd_en_o is low
    always_ff @(posedge clk) begin
        if (bus4.rd_en_o) begin
            bus4.a_rdata_i <= mem_a[bus4.rd_addr_o];
            bus4.b_rdata_i <= mem_b[bus4.rd_addr_o];
        end
        if (bus256.rd_en_o) begin
            bus256.a_rdata_i <= mem_a[bus256.rd_addr_o];
            bus256.b_rdata_i <= mem_b[bus256.rd_addr_o];
        end
        if (bus1.rd_en_o) begin
            bus1.a_rdata_i <= mem_a[{7'd0, bus1.rd_addr_o}];
            bus1.b_rdata_i <= mem_b[{7'd0, bus1.rd_addr_o}];
        end
    end

    assign bus4.sub_c_i   = mod_sub(bus4.sub_a_o,   bus4.sub_b_o,   bus4.sub_q_o);
    assign bus256.sub_c_i = mod_sub(bus256.sub_a_o, bus256.sub_b_o, bus256.sub_q_o);
    assign bus1.sub_c_i   = mod_sub(bus1.sub_a_o,   bus1.sub_b_o,   bus1.sub_q_o);

    typedef struct {
        logic [7:0]  addr;
        logic [22:0] data;
    } exp_t;
    exp_t sb [$];

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc, eff, n_act, done_seen;
    logic run_active = 1'b0;
    logic [22:0] q_run;

    logic        o_busy, o_done, o_rd_en, o_wr_en;
    logic [7:0]  o_rd_addr, o_wr_addr;
    logic [22:0] o_wr_data, o_sub_q;
    logic [23:0] o_sub_a, o_sub_b;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s cycle %0d: observed 0x%0h expected 0x%0h", tag, cyc, obs, exp);
    endtask

    task automatic sample();
        case (sel)
            0: begin
                o_busy = bus4.busy_o; o_done = bus4.done_o; o_rd_en = bus4.rd_en_o;
                o_rd_addr = bus4.rd_addr_o; o_wr_en = bus4.wr_en_o; o_wr_addr = bus4.wr_addr_o;
                o_wr_data = bus4.wr_data_o; o_sub_q = bus4.sub_q_o;
                o_sub_a = bus4.sub_a_o; o_sub_b = bus4.sub_b_o;
            end
            1: begin
                o_busy = bus256.busy_o; o_done = bus256.done_o; o_rd_en = bus256.rd_en_o;
                o_rd_addr = bus256.rd_addr_o; o_wr_en = bus256.wr_en_o; o_wr_addr = bus256.wr_addr_o;
                o_wr_data = bus256.wr_data_o; o_sub_q = bus256.sub_q_o;
                o_sub_a = bus256.sub_a_o; o_sub_b = bus256.sub_b_o;
            end
            default: begin
                o_busy = bus1.busy_o; o_done = bus1.done_o; o_rd_en = bus1.rd_en_o;
                o_rd_addr = {7'd0, bus1.rd_addr_o}; o_wr_en = bus1.wr_en_o;
                o_wr_addr = {7'd0, bus1.wr_addr_o};
                o_wr_data = bus1.wr_data_o; o_sub_q = bus1.sub_q_o;
                o_sub_a = bus1.sub_a_o; o_sub_b = bus1.sub_b_o;
            end
        endcase
    endtask

    // eff counts unheld cycles since start, so expected timing shifts by one per held cycle
    task automatic tick();
        exp_t e;
        @(negedge clk);
        sample();
        if (o_done) done_seen++;
        if (run_active) begin
            check("rd_en", 32'(o_rd_en), 32'(!hold && eff >= 1 && eff <= n_act));
            if (!hold && eff >= 1 && eff <= n_act) check("rd_addr", 32'(o_rd_addr), 32'(eff - 1));
            check("busy", 32'(o_busy), 32'(eff >= 1 && eff <= n_act + 4));
            check("done", 32'(o_done), 32'(!hold && eff == n_act + 4));
            check("wr_en", 32'(o_wr_en), 32'(!hold && eff >= 4 && eff <= n_act + 3));
            if (eff >= 1) check("sub_q", 32'(o_sub_q), 32'(q_run));
        end else begin
            check("idle_rd_en", 32'(o_rd_en), 32'd0);
            check("idle_wr_en", 32'(o_wr_en), 32'd0);
            check("idle_done", 32'(o_done), 32'd0);
            check("idle_busy", 32'(o_busy), 32'd0);
        end
        if (o_wr_en) begin
            if (sb.size() == 0) begin
                check("wr_unexpected", 32'(o_wr_addr), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("wr_addr", 32'(o_wr_addr), 32'(e.addr));
                check("wr_data", 32'(o_wr_data), 32'(e.data));
            end
        end
        @(posedge clk);
        #1;
        if (!hold) eff++;
        cyc++;
    endtask

    task automatic run_op(int s, int n, logic [22:0] qv, int h1s, int h1l, int h2s, int h2l,
                          int st1, int st2, int rst_at, int exp_done);
        int len;
        sel = s; n_act = n; q_run = qv;
        cyc = 0; eff = 0; done_seen = 0;
        run_active = 1'b1;
        len = (rst_at >= 0) ? rst_at + 4 : n + 8 + h1l + h2l;
        for (int i = 0; i < len; i++) begin
            start = (cyc == 0) || (cyc == st1) || (cyc == st2);
            q     = (cyc == 0) ? qv : ~qv;
            hold  = (cyc >= h1s && cyc < h1s + h1l) || (cyc >= h2s && cyc < h2s + h2l);
            rst_n = (cyc != rst_at);
            if (rst_at >= 0 && cyc == rst_at + 1) begin
                run_active = 1'b0;
                sb.delete();
                sample();
                check("rst_sub_q", 32'(o_sub_q), 32'd0);
                check("rst_sub_a", 32'(o_sub_a), 32'd0);
                check("rst_sub_b", 32'(o_sub_b), 32'd0);
                check("rst_rd_addr", 32'(o_rd_addr), 32'd0);
                check("rst_wr_addr", 32'(o_wr_addr), 32'd0);
                check("rst_wr_data", 32'(o_wr_data), 32'd0);
            end
            tick();
        end
        start = 1'b0; hold = 1'b0; rst_n = 1'b1;
        run_active = 1'b0;
        check("done_count", 32'(done_seen), 32'(exp_done));
        check("sb_empty", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic load_small();
        mem_a[0] = 24'd5;  mem_b[0] = 24'd3;
        mem_a[1] = 24'd10; mem_b[1] = 24'd10;
        mem_a[2] = 24'd0;  mem_b[2] = 24'd1;
        mem_a[3] = 24'h7FE000; mem_b[3] = 24'd0;
        sb.push_back('{8'd0, 23'd2});
        sb.push_back('{8'd1, 23'd0});
        sb.push_back('{8'd2, 23'h7FE000});
        sb.push_back('{8'd3, 23'h7FE000});
    endtask

    task automatic load_random(logic [22:0] qv);
        for (int k = 0; k < 256; k++) begin
            mem_a[k] = 24'($urandom());
            mem_b[k] = 24'($urandom());
            sb.push_back('{8'(k), mod_sub(mem_a[k], mem_b[k], qv)});
        end
    endtask

    initial begin
        cyc = 0; eff = 0; n_act = 4; done_seen = 0; q_run = '0;
        rst_n = 1'b0;
        tick();
        sample();
        check("reset_sub_q", 32'(o_sub_q), 32'd0);
        check("reset_wr_data", 32'(o_wr_data), 32'd0);
        check("reset_rd_addr", 32'(o_rd_addr), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        load_small();
        run_op(0, 4, 23'h7FE001, -1, 0, -1, 0, -1, -1, -1, 1);

        load_small();
        run_op(0, 4, 23'h7FE001, 3, 3, 6, 2, -1, -1, -1, 1);

        load_small();
        run_op(0, 4, 23'h7FE001, -1, 0, -1, 0, 2, 5, -1, 1);

        load_random(23'h6D3410);
        run_op(1, 256, 23'h6D3410, -1, 0, -1, 0, -1, -1, -1, 1);

        load_random(23'h6D3410);
        run_op(1, 256, 23'h6D3410, -1, 0, -1, 0, -1, -1, 5, 0);
        tick();
        load_random(23'h6D3410);
        run_op(1, 256, 23'h6D3410, -1, 0, -1, 0, -1, -1, -1, 1);

        mem_a[0] = 24'd3; mem_b[0] = 24'd5;
        sb.push_back('{8'd0, 23'h7FDFFF});
        run_op(2, 1, 23'h7FE001, -1, 0, -1, 0, -1, -1, -1, 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/poly_sub_ctrl.md
Name: poly_sub_ctrl

Overview:
- Sequences element-wise modular subtraction of two N-coefficient polynomials, C[k] = (A[k] - B[k]) mod q, through one shared mod_sub instance.
- Reads A and B from two coefficient RAMs, which share one read address and have 1-cycle read latency.
- Drives the external combinational mod_sub operands and writes each result to the destination RAM.
- Sits between the top-level polynomial scheduler (start/done handshake) and the coefficient memories.

Parameters:
N, 256, number of coefficients per polynomial (N >= 1)
AW, 8, address width; must satisfy 2**AW >= N

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_n_i  in  1  synchronous active-low reset
start_i  in  1  start request, sampled only in IDLE
q_i  in  23  modulus, captured on accepted start
hold_i  in  1  stall: freezes the whole block while high
busy_o  out  1  high from accepted start until the done cycle inclusive
done_o  out  1  one-cycle pulse after the last write
rd_en_o  out  1  read enable to the A and B RAMs
rd_addr_o  out  AW  shared read address
a_rdata_i  in  24  A coefficient, valid the cycle after rd_en_o
b_rdata_i  in  24  B coefficient, valid the cycle after rd_en_o
sub_a_o  out  24  registered operand a to mod_sub
sub_b_o  out  24  registered operand b to mod_sub
sub_q_o  out  23  registered modulus to mod_sub
sub_c_i  in  23  mod_sub result (combinational from sub_*_o)
wr_en_o  out  1  destination RAM write enable
wr_addr_o  out  AW  destination address
wr_data_o  out  23  destination data

Behaviour:
- Reset (rst_n_i low at an edge): state IDLE; all outputs 0; read counter, pipeline valid bits and address registers cleared. Applies mid-operation: the operation is abandoned, no done_o pulse, and no further writes are issued.
- States:
  - IDLE: start_i=1 -> latch q_i into sub_q_o, clear counter, enter RUN. busy_o rises in the cycle after start.
  - RUN: each non-held cycle, rd_en_o=1 and rd_addr_o=counter, then the counter increments. After issuing address N-1, go to DRAIN.
  - DRAIN: rd_en_o=0; wait until both pipeline stages are empty, then go to DONE.
  - DONE: done_o=1 for one cycle, busy_o still 1; then IDLE.
- Pipeline for address k, all stages registered:
  - cycle t: read issued for k.
  - cycle t+1: a/b_rdata_i valid; captured into sub_a_o/sub_b_o along with addr k and a valid bit.
  - cycle t+2: sub_c_i valid; captured into wr_data_o/wr_addr_o.
  - cycle t+3: wr_en_o=1 for k.
- Timing with no hold (start sampled at cycle 0):
  - rd_en_o high cycles 1..N.
  - wr_en_o high cycles 4..N+3, addresses 0..N-1 in order, exactly once each.
  - done_o at cycle N+4; busy_o low from cycle N+5.
- hold_i=1:
  - No state, counter, valid bit or data register changes.
  - rd_en_o and wr_en_o are forced 0.
  - done_o is deferred, never dropped.
  - The RAMs hold their read data while rd_en_o=0, so operands are not lost.
  - When hold releases, the sequence continues exactly where it stopped.
- start_i outside IDLE is ignored; q_i changes after the start is accepted are ignored.
- The block performs no arithmetic. Result correctness is mod_sub's contract: (a<b ? a-b+q : a-b) mod 2^23. The controller forwards sub_c_i unmodified.
- N=1: a single read at cycle 1, a single write at cycle 4, done_o at cycle 5.
- Counter is AW bits wide. rd_addr_o never exceeds N-1; no wrap-around is permitted.
- start_i and hold_i high in the same cycle while IDLE: the start is not accepted; hold takes priority.

Test Plan:
- q=0x7FE001, N=4, A={5,10,0,0x7FE000}, B={3,10,1,0} -> writes {2,0,0x7FE000,0x7FE000} to addrs 0..3 at cycles 4..7; done_o at cycle 8; busy_o high cycles 1..8.
- q=0x6D3410, N=256, random 24-bit A/B -> each write equals the mod_sub reference model; 256 writes, no duplicated or missing address; done_o exactly once at cycle 260.
- Same as the first scenario, with hold_i high for 3 cycles at cycle 3 and 2 cycles at cycle 6 -> identical write data/address sequence; no writes or reads while held; done_o at cycle 13.
- start_i pulsed again at cycles 2 and 5 during the first scenario -> ignored; a single set of 4 writes and a single done_o.
- rst_n_i low for 1 cycle at cycle 5 of the N=256 run -> from the next edge all outputs 0, state IDLE, no done_o; a new start then completes normally.
- N=1 parameterisation, A={3}, B={5}, q=0x7FE001 -> single write of 0x7FDFFF to addr 0 at cycle 4; done_o at cycle 5.
